mem_arb_ctrl: RTL

- Round-robin controller that shares one small synchronous memory macro between NREQ requesters.
- Memory port: single write, single read, 1-cycle registered read data, active-low synchronous reset.
- Issues at most one memory operation per cycle and returns read data to the requester that issued the read.
- Provides a clear sequencer that writes zero to every word on command; the sequencer blocks all grants while it runs.

---
 rtl/mem_arb_pkg.sv | 22 ++
 rtl/mem_arb_ctrl_if.sv | 17 +
 rtl/mem_arb_rr.sv | 23 ++
 rtl/mem_arb_ctrl.sv | 139 +++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types and helpers for the round-robin memory arbiter.
package mem_arb_pkg;

   typedef enum logic {StIdle, StClear} state_e;

   localparam int unsigned STAT_W = 16;

   // Winner index for a search that starts at ptr and wraps modulo nreq; returns ptr if req is empty.
   function automatic logic [2:0] next_rr(input logic [2:0] ptr, input logic [7:0] req,
                                          input int nreq);
      int s;
      next_rr = ptr;
      for (int i = 7; i >= 0; i--) begin
         if (i < nreq) begin
            s = int'(ptr) + i;
            if (s >= nreq) s = s - nreq;
            if (req[s[2:0]]) next_rr = s[2:0];
         end
      end
   endfunction

endpackage

// File: rtl/mem_arb_ctrl_if.sv
// Requester-side bus of the memory arbiter: flattened per-requester requests and read returns.
interface mem_arb_ctrl_if #(
   parameter int unsigned NREQ  = 2,
   parameter int unsigned WIDTH = 8,
   parameter int unsigned PSIZE = 3
) ();
   logic [NREQ-1:0]       req;
   logic [NREQ-1:0]       req_we;
   logic [NREQ*PSIZE-1:0] req_addr;
   logic [NREQ*WIDTH-1:0] req_wdata;
   logic [NREQ-1:0]       gnt;
   logic [NREQ-1:0]       rvalid;
   logic [WIDTH-1:0]      rdata;

   modport master (output req, req_we, req_addr, req_wdata, input gnt, rvalid, rdata);
   modport slave  (input req, req_we, req_addr, req_wdata, output gnt, rvalid, rdata);
endinterface

// File: rtl/mem_arb_rr.sv
// Combinational round-robin pick: one-hot grant and winner index from req and start pointer.
module mem_arb_rr
   import mem_arb_pkg::*;
#(
   parameter int unsigned NREQ = 2
) (
   input  logic [NREQ-1:0] req_i,
   input  logic [2:0]      ptr_i,
   output logic [NREQ-1:0] gnt_o,
   output logic [2:0]      idx_o
);
   logic [7:0] req_ext;

   always_comb begin
      req_ext = '0;
      req_ext[NREQ-1:0] = req_i;
      idx_o = next_rr(ptr_i, req_ext, int'(NREQ));
      gnt_o = '0;
      for (int k = 0; k < NREQ; k++) begin
         gnt_o[k] = (|req_i) && (idx_o == 3'(k));
      end
   end
endmodule

// File: rtl/mem_arb_ctrl.sv
// Round-robin controller sharing one sync memory between NREQ requesters, with a clear sequencer.
// Optional per-requester grant counters when MEM_ARB_STATS_EN is defined.
module mem_arb_ctrl
   import mem_arb_pkg::*;
#(
   parameter int unsigned NREQ  = 2,
   parameter int unsigned WIDTH = 8,
   parameter int unsigned PSIZE = 3
) (
   input  logic             clk,
   input  logic             rst_n,
   mem_arb_ctrl_if.slave    bus,
   input  logic             clr_req_i,
   output logic             clr_busy_o,
   output logic             clr_done_o,
   output logic             mem_wr_o,
   output logic             mem_rd_o,
   output logic [PSIZE-1:0] mem_wr_addr_o,
   output logic [PSIZE-1:0] mem_rd_addr_o,
   output logic [WIDTH-1:0] mem_wdata_o,
   input  logic [WIDTH-1:0] mem_rdata_i
`ifdef MEM_ARB_STATS_EN
   ,
   output logic [NREQ*STAT_W-1:0] grant_cnt_o
`endif
);
   localparam int unsigned DEPTH = 2 ** PSIZE;

   state_e           state_q, state_d;
   logic [2:0]       ptr_q, ptr_d;
   logic [PSIZE-1:0] cnt_q, cnt_d;
   logic             pend_q, pend_d;
   logic [2:0]       owner_q, owner_d;
   logic [NREQ-1:0]  rr_gnt;
   logic [2:0]       rr_idx;
   logic             we_sel;

   mem_arb_rr #(.NREQ(NREQ)) u_rr (
      .req_i (bus.req),
      .ptr_i (ptr_q),
      .gnt_o (rr_gnt),
      .idx_o (rr_idx)
   );

   assign we_sel = |(bus.req_we & rr_gnt);

   // Combinational outputs are held at zero while reset is asserted.
   always_comb begin
      state_d       = state_q;
      ptr_d         = ptr_q;
      cnt_d         = cnt_q;
      pend_d        = 1'b0;
      owner_d       = owner_q;
      bus.gnt       = '0;
      bus.rvalid    = '0;
      bus.rdata     = '0;
      mem_wr_o      = 1'b0;
      mem_rd_o      = 1'b0;
      mem_wr_addr_o = '0;
      mem_rd_addr_o = '0;
      mem_wdata_o   = '0;
      clr_busy_o    = 1'b0;
      clr_done_o    = 1'b0;
      if (rst_n) begin
         for (int k = 0; k < NREQ; k++) begin
            bus.rvalid[k] = pend_q && (owner_q == 3'(k));
         end
         if (pend_q) bus.rdata = mem_rdata_i;
         unique case (state_q)
            StIdle: begin
               if (clr_req_i) begin
                  state_d = StClear;
                  cnt_d   = '0;
               end else if (|bus.req) begin
                  bus.gnt = rr_gnt;
                  ptr_d   = (rr_idx == 3'(NREQ - 1)) ? 3'd0 : rr_idx + 3'd1;
                  if (we_sel) begin
                     mem_wr_o      = 1'b1;
                     mem_wr_addr_o = bus.req_addr[int'(rr_idx)*PSIZE +: PSIZE];
                     mem_wdata_o   = bus.req_wdata[int'(rr_idx)*WIDTH +: WIDTH];
                  end else begin
                     mem_rd_o      = 1'b1;
                     mem_rd_addr_o = bus.req_addr[int'(rr_idx)*PSIZE +: PSIZE];
                     pend_d        = 1'b1;
                     owner_d       = rr_idx;
                  end
               end
            end
            StClear: begin
               clr_busy_o    = 1'b1;
               mem_wr_o      = 1'b1;
               mem_wr_addr_o = cnt_q;
               cnt_d         = cnt_q + 1'b1;
               if (cnt_q == PSIZE'(DEPTH - 1)) begin
                  clr_done_o = 1'b1;
                  state_d    = StIdle;
               end
            end
            default: state_d = StIdle;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= StIdle;
         ptr_q   <= '0;
         cnt_q   <= '0;
         pend_q  <= 1'b0;
         owner_q <= '0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         cnt_q   <= cnt_d;
         pend_q  <= pend_d;
         owner_q <= owner_d;
      end
   end

`ifdef MEM_ARB_STATS_EN
   logic [NREQ-1:0][STAT_W-1:0] gcnt_q;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         gcnt_q <= '0;
      end else begin
         for (int k = 0; k < NREQ; k++) begin
            if (state_q == StIdle && clr_req_i) begin
               gcnt_q[k] <= '0;
            end else if (bus.gnt[k] && gcnt_q[k] != '1) begin
               gcnt_q[k] <= gcnt_q[k] + 1'b1;
            end
         end
      end
   end

   assign grant_cnt_o = gcnt_q;
`endif
endmodule
